// File: rtl/nvio3_bitfield_fu.sv
// Pipelined bitfield functional unit: S1 operand register, combinational bitfield datapath, credit-managed result FIFO.
// Optional build macro BF_MASK_OUT_EN adds res_mask_o, carrying each result's generated field mask through the FIFO.
`timescale 1ns/1ps

module nvio3_bitfield_fu #(
    parameter int unsigned DWIDTH     = 128,
    parameter int unsigned TAGW       = 5,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              issue_valid_i,
    output logic              issue_ready_o,
    input  logic [39:0]       issue_inst_i,
    input  logic [DWIDTH-1:0] issue_a_i,
    input  logic [DWIDTH-1:0] issue_b_i,
    input  logic [DWIDTH-1:0] issue_c_i,
    input  logic [TAGW-1:0]   issue_tag_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [DWIDTH-1:0] res_data_o,
    output logic [TAGW-1:0]   res_tag_o,
    output logic              res_exc_o,
`ifdef BF_MASK_OUT_EN
    output logic [DWIDTH-1:0] res_mask_o,
`endif
    output logic              busy_o
);

    localparam int unsigned IW  = 40;
    localparam int unsigned MBW = $clog2(DWIDTH);
    localparam int unsigned EW  = MBW + 1;
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = PW + 1;

    localparam logic [3:0] OP_SET  = 4'h0;
    localparam logic [3:0] OP_CLR  = 4'h1;
    localparam logic [3:0] OP_CHG  = 4'h2;
    localparam logic [3:0] OP_INS  = 4'h3;
    localparam logic [3:0] OP_INSI = 4'h4;
    localparam logic [3:0] OP_EXT  = 4'h5;
    localparam logic [3:0] OP_EXTU = 4'h6;
    localparam logic [3:0] OP_FFO  = 4'h8;

    typedef struct packed {
        logic [DWIDTH-1:0] data;
        logic [TAGW-1:0]   tag;
        logic              exc;
`ifdef BF_MASK_OUT_EN
        logic [DWIDTH-1:0] mask;
`endif
    } entry_t;

    // ---------------- S1 operand register ----------------
    logic              s1_valid;
    logic [IW-1:0]     s1_inst;
    logic [DWIDTH-1:0] s1_a;
    logic [DWIDTH-1:0] s1_b;
    logic [DWIDTH-1:0] s1_c;
    logic [TAGW-1:0]   s1_tag;
    logic              accept;

    assign accept = issue_valid_i & issue_ready_o & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_inst  <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c     <= '0;
            s1_tag   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_inst <= issue_inst_i;
                s1_a    <= issue_a_i;
                s1_b    <= issue_b_i;
                s1_c    <= issue_c_i;
                s1_tag  <= issue_tag_i;
            end
        end
    end

    // Reserved instruction bits and the high part of the dynamic width operand are ignored.
    logic unused_bits;
    assign unused_bits = ^{s1_inst[32:23], s1_b[DWIDTH-1:MBW]};

    // ---------------- Bitfield datapath ----------------
    logic [3:0]        op;
    logic [MBW-1:0]    mb;
    logic [MBW-1:0]    mw;
    logic [MBW-1:0]    w1;
    logic [EW-1:0]     me;
    logic [EW-1:0]     sh;
    logic [DWIDTH-1:0] da;
    logic [DWIDTH-1:0] mask;
    logic [DWIDTH-1:0] field;
    logic [DWIDTH-1:0] ext_s;
    logic [DWIDTH-1:0] ffo;
    logic [DWIDTH-1:0] insi_imm;
    logic [DWIDTH-1:0] dp_result;
    logic              dp_exc;

    // Field start/width: mw encodes the offset of the last field bit, so the field spans mb..mb+mw.
    always_comb begin
        op       = s1_inst[39:36];
        mb       = s1_inst[34] ? s1_a[MBW-1:0] : MBW'(s1_inst[15:10]);
        mw       = s1_inst[33] ? s1_b[MBW-1:0] : MBW'(s1_inst[22:16]);
        da       = s1_inst[35] ? s1_c : s1_a;
        insi_imm = DWIDTH'(s1_inst[9:0]);
        me       = EW'(mb) + EW'(mw);
    end

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < DWIDTH; i++) begin
            mask[i] = (EW'(i) >= EW'(mb)) && (EW'(i) <= me);
        end
    end

    // Fields running past the MSB are clipped, so the sign bit is the last bit actually inside the word.
    always_comb begin
        w1    = (me > EW'(DWIDTH - 1)) ? MBW'(EW'(DWIDTH - 1) - EW'(mb)) : mw;
        sh    = EW'(DWIDTH - 1) - EW'(w1);
        field = (da & mask) >> mb;
        ext_s = $signed(field << sh) >>> sh;
    end

    // Lowest set bit inside the field; all-ones when the field is empty of ones.
    always_comb begin
        ffo = '1;
        for (int i = DWIDTH - 1; i >= 0; i--) begin
            if (da[i] & mask[i]) ffo = DWIDTH'(i);
        end
    end

    always_comb begin
        dp_result = '0;
        dp_exc    = 1'b0;
        case (op)
            OP_SET:  dp_result = da | mask;
            OP_CLR:  dp_result = da & ~mask;
            OP_CHG:  dp_result = da ^ mask;
            OP_INS:  dp_result = (da & ~mask) | ((s1_a << mb) & mask);
            OP_INSI: dp_result = (da & ~mask) | ((insi_imm << mb) & mask);
            OP_EXT:  dp_result = ext_s;
            OP_EXTU: dp_result = field;
            OP_FFO:  dp_result = ffo;
            default: dp_exc    = 1'b1;
        endcase
    end

    // ---------------- Result FIFO with registered head ----------------
    entry_t         mem [FIFO_DEPTH];
    entry_t         push_e;
    entry_t         head_q;
    entry_t         head_n;
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_n;
    logic [PW-1:0]  wr_n;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_n;
    logic [CW-1:0]  left;
    logic           push;
    logic           pop;
    logic           valid_n;
    logic           ready_n;
    logic           busy_n;

    always_comb begin
        push_e      = '0;
        push_e.data = dp_result;
        push_e.tag  = s1_tag;
        push_e.exc  = dp_exc;
`ifdef BF_MASK_OUT_EN
        push_e.mask = mask;
`endif
    end

    // Next head is the pushed entry when nothing older survives the pop, otherwise the next stored entry.
    always_comb begin
        push    = s1_valid & ~flush_i;
        pop     = res_valid_o & res_ready_i & ~flush_i;
        left    = count - CW'(pop);
        count_n = left + CW'(push);
        rd_n    = rd_ptr + PW'(pop);
        wr_n    = wr_ptr + PW'(push);
        if (flush_i) begin
            count_n = '0;
            rd_n    = '0;
            wr_n    = '0;
        end
        head_n = '0;
        if (count_n == '0) begin
            head_n = '0;
        end else if (left == '0) begin
            head_n = push_e;
        end else begin
            head_n = mem[rd_n];
        end
        valid_n = (count_n != '0);
        ready_n = (count_n + CW'(accept)) < CW'(FIFO_DEPTH);
        busy_n  = accept | valid_n;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            head_q        <= '0;
            res_valid_o   <= 1'b0;
            issue_ready_o <= 1'b1;
            busy_o        <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            rd_ptr        <= rd_n;
            wr_ptr        <= wr_n;
            count         <= count_n;
            head_q        <= head_n;
            res_valid_o   <= valid_n;
            issue_ready_o <= ready_n;
            busy_o        <= busy_n;
            if (push) mem[wr_ptr] <= push_e;
        end
    end

    assign res_data_o = head_q.data;
    assign res_tag_o  = head_q.tag;
    assign res_exc_o  = head_q.exc;
`ifdef BF_MASK_OUT_EN
    assign res_mask_o = head_q.mask;
`endif

    // Credit accounting must make a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && (count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_nvio3_bitfield_fu.sv
// Directed + random bench for nvio3_bitfield_fu with an expected-result queue checked at each CDB pop.
`timescale 1ns/1ps

module tb_nvio3_bitfield_fu;

    localparam int unsigned DW = 128;
    localparam int unsigned TW = 5;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush_i = 1'b0;
    logic          issue_valid_i = 1'b0;
    logic          issue_ready_o;
    logic [39:0]   issue_inst_i = '0;
    logic [DW-1:0] issue_a_i = '0;
    logic [DW-1:0] issue_b_i = '0;
    logic [DW-1:0] issue_c_i = '0;
    logic [TW-1:0] issue_tag_i = '0;
    logic          res_valid_o;
    logic          res_ready_i = 1'b0;
    logic [DW-1:0] res_data_o;
    logic [TW-1:0] res_tag_o;
    logic          res_exc_o;
    logic          busy_o;

    nvio3_bitfield_fu dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .issue_valid_i (issue_valid_i),
        .issue_ready_o (issue_ready_o),
        .issue_inst_i  (issue_inst_i),
        .issue_a_i     (issue_a_i),
        .issue_b_i     (issue_b_i),
        .issue_c_i     (issue_c_i),
        .issue_tag_i   (issue_tag_i),
        .res_valid_o   (res_valid_o),
        .res_ready_i   (res_ready_i),
        .res_data_o    (res_data_o),
        .res_tag_o     (res_tag_o),
        .res_exc_o     (res_exc_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        logic          exc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    int unsigned last_pop = 0;
    int unsigned prev_pop = 0;
    int unsigned n_pops = 0;
    bit          rr_en = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: bit-by-bit field walk; returns {exc, data}.
    function automatic logic [DW:0] model(input logic [39:0] inst, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b, input logic [DW-1:0] c);
        logic [3:0]    op;
        int            mb;
        int            mw;
        int            last;
        logic [DW-1:0] da;
        logic [DW-1:0] m;
        logic [DW-1:0] r;
        logic [DW-1:0] fld;
        logic [DW-1:0] src;
        op   = inst[39:36];
        mb   = inst[34] ? int'(a[6:0]) : int'(inst[15:10]);
        mw   = inst[33] ? int'(b[6:0]) : int'(inst[22:16]);
        da   = inst[35] ? c : a;
        m    = '0;
        fld  = '0;
        last = 0;
        for (int i = 0; i < int'(DW); i++) m[i] = (i >= mb) && (i <= mb + mw);
        for (int k = 0; k <= mw; k++) begin
            if (mb + k < int'(DW)) begin
                fld[k] = da[mb + k];
                last   = k;
            end
        end
        r = '0;
        case (op)
            4'h0: r = da | m;
            4'h1: r = da & ~m;
            4'h2: r = da ^ m;
            4'h3, 4'h4: begin
                src = (op == 4'h3) ? a : DW'(inst[9:0]);
                r   = da;
                for (int k = 0; k <= mw; k++) if (mb + k < int'(DW)) r[mb + k] = src[k];
            end
            4'h5: begin
                r = fld;
                for (int k = last + 1; k < int'(DW); k++) r[k] = fld[last];
            end
            4'h6: r = fld;
            4'h8: begin
                r = '1;
                for (int i = int'(DW) - 1; i >= 0; i--) if (m[i] & da[i]) r = DW'(i);
            end
            default: return {1'b1, {DW{1'b0}}};
        endcase
        return {1'b0, r};
    endfunction

    // Scoreboard: every accepted CDB pop is compared against the oldest expectation.
    always @(negedge clk_i) begin
        if (rst_ni && res_valid_o && res_ready_i && !flush_i) begin
            exp_t e;
            n_checks++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_result: observed tag %0d expected no result", res_tag_o);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("res_data", res_data_o, e.data);
                chk("res_tag", DW'(res_tag_o), DW'(e.tag));
                chk("res_exc", DW'(res_exc_o), DW'(e.exc));
                prev_pop = last_pop;
                last_pop = cyc;
                n_pops++;
            end
        end
    end

    task automatic issue(input logic [39:0] inst, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c, input logic [TW-1:0] tag,
                         input logic [DW-1:0] edata, input logic eexc, input bit track);
        int waitc;
        bit done;
        exp_t e;
        waitc = 0;
        done  = 1'b0;
        issue_valid_i = 1'b1;
        issue_inst_i  = inst;
        issue_a_i     = a;
        issue_b_i     = b;
        issue_c_i     = c;
        issue_tag_i   = tag;
        while (!done) begin
            @(negedge clk_i);
            if (issue_ready_o) begin
                if (track) begin
                    e.data = edata;
                    e.tag  = tag;
                    e.exc  = eexc;
                    sb.push_back(e);
                end
                done = 1'b1;
            end else begin
                waitc++;
                if (waitc > 50) begin
                    n_checks++;
                    n_fail++;
                    $error("FAIL issue_timeout: observed issue_ready_o=0 for %0d cycles expected 1", waitc);
                    done = 1'b1;
                end
            end
            @(posedge clk_i);
            #1;
            if (rr_en) res_ready_i = 1'($urandom_range(0, 1));
        end
        issue_valid_i = 1'b0;
    endtask

    task automatic issue_m(input logic [39:0] inst, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] c, input logic [TW-1:0] tag);
        logic [DW:0] r;
        r = model(inst, a, b, c);
        issue(inst, a, b, c, tag, r[DW-1:0], r[DW], 1'b1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        res_ready_i = 1'b1;
        while ((sb.size() != 0 || busy_o) && k < 100) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        n_checks++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL drain: observed %0d results outstanding expected 0", sb.size());
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed simulation still running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  ops [8];
        logic [39:0] inst;
        int unsigned pops0;
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8};

        // Reset
        repeat (3) @(negedge clk_i);
        chk("rst_res_valid", DW'(res_valid_o), DW'(0));
        chk("rst_busy", DW'(busy_o), DW'(0));
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("idle_issue_ready", DW'(issue_ready_o), DW'(1));
        chk("idle_res_valid", DW'(res_valid_o), DW'(0));
        chk("idle_busy", DW'(busy_o), DW'(0));
        chk("idle_res_data", res_data_o, DW'(0));
        chk("idle_res_tag", DW'(res_tag_o), DW'(0));
        @(posedge clk_i);
        #1;

        // BFSET latency: accepted at N, visible at N+2
        res_ready_i = 1'b1;
        issue(40'h0800031000, '0, '0, '0, 5'd3, DW'(128'hF0), 1'b0, 1'b1);
        @(negedge clk_i);
        chk("set_n1_valid", DW'(res_valid_o), DW'(0));
        chk("set_n1_busy", DW'(busy_o), DW'(1));
        @(negedge clk_i);
        chk("set_n2_valid", DW'(res_valid_o), DW'(1));
        chk("set_n2_data", res_data_o, DW'(128'hF0));
        chk("set_n2_tag", DW'(res_tag_o), DW'(3));
        chk("set_n2_exc", DW'(res_exc_o), DW'(0));
        @(posedge clk_i);
        #1;

        // Back-to-back EXTU then BFCLR
        pops0 = n_pops;
        issue(40'h6800031000, '0, '0, DW'(128'hAB), 5'd4, DW'(128'hA), 1'b0, 1'b1);
        issue(40'h1800031000, '0, '0, DW'(128'hFF), 5'd5, DW'(128'h0F), 1'b0, 1'b1);
        repeat (4) @(posedge clk_i);
        #1;
        chk("b2b_pop_count", DW'(n_pops - pops0), DW'(2));
        chk("b2b_consecutive", DW'(last_pop - prev_pop), DW'(1));

        // Backpressure: third op must wait for the CDB
        res_ready_i = 1'b0;
        issue(40'h2800031000, '0, '0, DW'(128'h0F), 5'd8, DW'(128'hFF), 1'b0, 1'b1);
        issue(40'h6800031000, '0, '0, DW'(128'h5A0), 5'd9, DW'(128'hA), 1'b0, 1'b1);
        issue_valid_i = 1'b1;
        issue_inst_i  = 40'h0800031000;
        issue_c_i     = DW'(128'h100);
        issue_tag_i   = 5'd10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("bp_issue_ready", DW'(issue_ready_o), DW'(0));
            chk("bp_res_valid", DW'(res_valid_o), DW'(1));
            chk("bp_data_stable", res_data_o, DW'(128'hFF));
            @(posedge clk_i);
            #1;
        end
        res_ready_i = 1'b1;
        issue(40'h0800031000, '0, '0, DW'(128'h100), 5'd10, DW'(128'h1F0), 1'b0, 1'b1);
        drain();
        @(negedge clk_i);
        chk("bp_ready_back", DW'(issue_ready_o), DW'(1));
        chk("bp_busy_clear", DW'(busy_o), DW'(0));
        @(posedge clk_i);
        #1;

        // Flush with one result queued and one in S1
        res_ready_i = 1'b0;
        issue(40'h0800031000, '0, '0, '0, 5'd20, '0, 1'b0, 1'b0);
        issue(40'h1800031000, '0, '0, '1, 5'd21, '0, 1'b0, 1'b0);
        flush_i       = 1'b1;
        res_ready_i   = 1'b1;
        issue_valid_i = 1'b1;
        issue_tag_i   = 5'd23;
        @(posedge clk_i);
        #1;
        flush_i       = 1'b0;
        issue_valid_i = 1'b0;
        @(negedge clk_i);
        chk("flush_res_valid", DW'(res_valid_o), DW'(0));
        chk("flush_busy", DW'(busy_o), DW'(0));
        chk("flush_issue_ready", DW'(issue_ready_o), DW'(1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("flush_quiet", DW'(res_valid_o), DW'(0));
        end

        // Issue handshake during a flush is discarded
        @(posedge clk_i);
        #1;
        flush_i       = 1'b1;
        issue_valid_i = 1'b1;
        issue_inst_i  = 40'h0800031000;
        issue_tag_i   = 5'd24;
        @(posedge clk_i);
        #1;
        flush_i       = 1'b0;
        issue_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("flush_issue_busy", DW'(busy_o), DW'(0));
            chk("flush_issue_valid", DW'(res_valid_o), DW'(0));
        end
        @(posedge clk_i);
        #1;

        // Illegal op
        issue(40'hF800031000, '0, '0, DW'(128'hFF), 5'd7, '0, 1'b1, 1'b1);
        drain();

        // Random legal ops with random CDB grants
        rr_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            inst = {ops[$urandom_range(0, 7)], 3'($urandom_range(0, 7)), 10'($urandom()),
                    7'($urandom()), 6'($urandom()), 10'($urandom())};
            issue_m(inst, {$urandom(), $urandom(), $urandom(), $urandom()},
                    {$urandom(), $urandom(), $urandom(), $urandom()},
                    {$urandom(), $urandom(), $urandom(), $urandom()}, 5'(i));
        end
        rr_en = 1'b0;
        drain();
        @(negedge clk_i);
        chk("end_busy", DW'(busy_o), DW'(0));
        chk("end_issue_ready", DW'(issue_ready_o), DW'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
